dcache_direct_mapped: RTL and testbench

//   Responder end of the pipeline's D-cache interface: serves DCACHE_ren/wen/addr/wdata, returns rdata and stall.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_line_array.sv | 56 +++++
 rtl/dcache_direct_mapped.sv | 158 +++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Build option: DCACHE_PERF_CNT_EN adds hit/miss counters to dcache_direct_mapped.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 2;
  localparam int WORDS    = 4;

  function automatic int idx_w(input int num_block);
    return $clog2(num_block);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_block);
    return addr_w - OFFSET_W - $clog2(num_block);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the cache: one async read port, one write
// port that either updates a single word (marking it dirty) or fills a whole line.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCK = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [BLOCK_W-1:0]  rd_data_o,
  input  logic                we_word_i,
  input  logic                we_fill_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [31:0]         wr_word_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [BLOCK_W-1:0]  wr_line_i
);

  logic [NUM_BLOCK-1:0] valid_q;
  logic [NUM_BLOCK-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_BLOCK];
  logic [BLOCK_W-1:0]   data_q [NUM_BLOCK];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // A fill always leaves the line clean; a word write always leaves it dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_BLOCK; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (we_fill_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
      tag_q[wr_idx_i]   <= wr_tag_i;
      data_q[wr_idx_i]  <= wr_line_i;
    end else if (we_word_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
      data_q[wr_idx_i][{wr_off_i, 5'b00000} +: 32] <= wr_word_i;
    end
  end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate D-cache between the core MEM stage and memory.
// Build option: DCACHE_PERF_CNT_EN adds hit_cnt/miss_cnt output ports.
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCK = 8,
  parameter int ADDR_W    = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic                proc_stall,
  output logic [31:0]         proc_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [BLOCK_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0]  mem_rdata,
`ifdef DCACHE_PERF_CNT_EN
  input  logic                mem_ready,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`else
  input  logic                mem_ready
`endif
);

  localparam int IDX_W = idx_w(NUM_BLOCK);
  localparam int TAG_W = tag_w(ADDR_W, NUM_BLOCK);

  state_e                  state_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [ADDR_W-3:0]       mem_addr_q;
  logic [BLOCK_W-1:0]      mem_wdata_q;

  logic [OFFSET_W-1:0]     req_off;
  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    line_valid;
  logic                    line_dirty;
  logic [TAG_W-1:0]        line_tag;
  logic [BLOCK_W-1:0]      line_data;
  logic                    req;
  logic                    rd_req;
  logic                    hit;
  logic                    idle;
  logic                    we_word;
  logic                    we_fill;

  assign req_off = proc_addr[OFFSET_W-1:0];
  assign req_idx = proc_addr[OFFSET_W +: IDX_W];
  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];

  dcache_line_array #(
    .NUM_BLOCK (NUM_BLOCK),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (line_valid),
    .rd_dirty_o (line_dirty),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_word_i  (we_word),
    .we_fill_i  (we_fill),
    .wr_idx_i   (req_idx),
    .wr_off_i   (req_off),
    .wr_word_i  (proc_wdata),
    .wr_tag_i   (req_tag),
    .wr_line_i  (mem_rdata)
  );

  // Write wins over read when the core illegally raises both.
  assign req     = proc_read | proc_write;
  assign rd_req  = proc_read & ~proc_write;
  assign idle    = (state_q == ST_IDLE);
  assign hit     = line_valid && (line_tag == req_tag);
  assign we_word = idle && proc_write && hit;
  assign we_fill = (state_q == ST_ALLOCATE) && mem_ready;

  assign proc_stall = req && !(idle && hit);
  assign proc_rdata = rd_req ? line_data[{req_off, 5'b00000} +: 32] : 32'd0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= ST_WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, req_idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= ST_ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= proc_addr[ADDR_W-1:OFFSET_W];
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state_q     <= ST_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= proc_addr[ADDR_W-1:OFFSET_W];
          end
        end
        ST_ALLOCATE: begin
          // The line itself is filled by the array; the held request hits next cycle.
          if (mem_ready) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (idle && req) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(proc_read && proc_write));

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a fixed-latency block memory responder.
module tb_dcache_direct_mapped;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic resp_en = 1'b1;
  int   wait_cnt = 0;
  logic [127:0] model [int];
  localparam int LAT = 3;

  dcache_direct_mapped #(.NUM_BLOCK(8), .ADDR_W(30)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef DCACHE_PERF_CNT_EN
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`else
    .mem_ready  (mem_ready)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Untouched memory holds word address + 0x10000000 in every word.
  function automatic logic [127:0] blk_pat(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'h1000_0000 + 32'(b * 4 + w);
    return r;
  endfunction

  function automatic logic [127:0] model_rd(input int b);
    if (model.exists(b)) return model[b];
    return blk_pat(b);
  endfunction

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (resp_en && rst_n && (mem_read || mem_write)) begin
        wait_cnt++;
        if (wait_cnt == LAT) begin
          if (mem_write) model[int'(mem_addr)] = mem_wdata;
          else           mem_rdata = model_rd(int'(mem_addr));
          mem_ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one access at posedge+1, waits (bounded) for stall to drop, completes it.
  task automatic access(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    proc_addr  = a;
    proc_wdata = wd;
    proc_write = wr;
    proc_read  = !wr;
    cyc = 0;
    #1;
    while (proc_stall && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd = proc_rdata;
    @(posedge clk); #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [15];

  task automatic run_vec(input int i);
    logic [31:0] rd;
    int cyc;
    access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, cyc);
    chk($sformatf("v%0d_cycles", i), 128'(cyc), 128'(vecs[i].exp_cyc));
    if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rdata));
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{1'b0, 30'h11, 32'h0,        32'h1000_0011, 0};
    vecs[1]  = '{1'b1, 30'h12, 32'hDEADBEEF, 32'h0,         0};
    vecs[2]  = '{1'b0, 30'h12, 32'h0,        32'hDEADBEEF,  0};
    vecs[3]  = '{1'b0, 30'h50, 32'h0,        32'h1000_0050, 4};
    vecs[4]  = '{1'b0, 30'h10, 32'h0,        32'h1000_0010, 4};
    vecs[5]  = '{1'b0, 30'h12, 32'h0,        32'hDEADBEEF,  0};
    vecs[6]  = '{1'b1, 30'h24, 32'h12345678, 32'h0,         4};
    vecs[7]  = '{1'b0, 30'h24, 32'h0,        32'h12345678,  0};
    vecs[8]  = '{1'b0, 30'h64, 32'h0,        32'h1000_0064, 8};
    vecs[9]  = '{1'b0, 30'h27, 32'h0,        32'h1000_0027, 4};
    vecs[10] = '{1'b0, 30'h24, 32'h0,        32'h12345678,  0};
    vecs[11] = '{1'b0, 30'h1F, 32'h0,        32'h1000_001F, 4};
    vecs[12] = '{1'b0, 30'h10, 32'h0,        32'h1000_0010, 4};
    vecs[13] = '{1'b0, 30'h12, 32'h0,        32'hDEADBEEF,  0};
    vecs[14] = '{1'b0, 30'h24, 32'h0,        32'h12345678,  4};

    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_stall", 128'(proc_stall), 128'(0));
    chk("rst_rdata", 128'(proc_rdata), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", 128'(proc_stall), 128'(0));
`ifdef DCACHE_PERF_CNT_EN
    chk("rst_hit_cnt", 128'(hit_cnt), 128'(0));
    chk("rst_miss_cnt", 128'(miss_cnt), 128'(0));
`endif

    // Cold read miss: stall in the same cycle, fill, then data one cycle after ready.
    proc_addr = 30'h10; proc_read = 1'b1;
    #1;
    chk("t1_stall_now", 128'(proc_stall), 128'(1));
    @(posedge clk); #1;
    chk("t1_mem_read", 128'(mem_read), 128'(1));
    chk("t1_mem_write", 128'(mem_write), 128'(0));
    chk("t1_mem_addr", 128'(mem_addr), 128'(4));
    cyc = 1;
    while (proc_stall && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("t1_latency", 128'(cyc), 128'(4));
    chk("t1_rdata", 128'(proc_rdata), 128'h1000_0010);
    chk("t1_mem_read_drop", 128'(mem_read), 128'(0));
    @(posedge clk); #1;
    proc_read = 1'b0;

    for (int i = 0; i <= 2; i++) run_vec(i);

    // Dirty conflict: write-back of the victim, then fill of the new block.
    proc_addr = 30'h30; proc_read = 1'b1;
    #1;
    chk("t3_stall_now", 128'(proc_stall), 128'(1));
    @(posedge clk); #1;
    chk("t3_mem_write", 128'(mem_write), 128'(1));
    chk("t3_mem_read_low", 128'(mem_read), 128'(0));
    chk("t3_wb_addr", 128'(mem_addr), 128'(4));
    chk("t3_wb_data", mem_wdata, {32'h1000_0013, 32'hDEADBEEF, 32'h1000_0011, 32'h1000_0010});
    cyc = 0;
    while (!mem_read && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("t3_fill_read", 128'(mem_read), 128'(1));
    chk("t3_fill_write_low", 128'(mem_write), 128'(0));
    chk("t3_fill_addr", 128'(mem_addr), 128'hC);
    cyc = 0;
    while (proc_stall && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("t3_stall_done", 128'(proc_stall), 128'(0));
    chk("t3_rdata", 128'(proc_rdata), 128'h1000_0030);
    @(posedge clk); #1;
    proc_read = 1'b0;

    run_vec(3);
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_cnt", 128'(hit_cnt), 128'(6));
    chk("miss_cnt", 128'(miss_cnt), 128'(3));
`endif
    for (int i = 4; i <= 11; i++) run_vec(i);

    // Reset in the middle of a fill abandons the transaction and invalidates all lines.
    resp_en = 1'b0;
    proc_addr = 30'h40; proc_read = 1'b1;
    @(posedge clk); #1;
    chk("t5_mem_read", 128'(mem_read), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_mem_read_rst", 128'(mem_read), 128'(0));
    chk("t5_mem_addr_rst", 128'(mem_addr), 128'(0));
    proc_read = 1'b0;
    #1;
    chk("t5_stall_rst", 128'(proc_stall), 128'(0));
    chk("t5_rdata_rst", 128'(proc_rdata), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 12; i <= 14; i++) run_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
